// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the RAM port sequencer: requester status codes,
// bus widths and load/store size encodings, plus a size-to-byte-count helper.
// No logic or latency of its own; no flow control.
package mem_ctrl_pkg;

    localparam int ADDRLEN = 32;
    localparam int INSTLEN = 32;

    // Status codes shown to each requester
    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // ls_size encodings
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // Number of RAM byte cycles for an LS access; the unused code 11 is treated as a word
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SIZE_B:  size_to_len = 3'd1;
            SIZE_H:  size_to_len = 3'd2;
            default: size_to_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between IF fetches and LS accesses (optional MC_IO_STALL_EN IO-store stall).
// Latency: N-byte read Done after edge E(N+RAM_LAT); N-byte write Done after edge E(N); Done lasts 1 cycle.
// Backpressure: non-preemptive, LS wins at accept; the loser sees Init and is accepted in a later IDLE cycle.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_LAT = 1
`ifdef MC_IO_STALL_EN
    ,
    parameter logic [ADDRLEN-1:0] IO_ADDR = 32'h0003_0000
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               if_readwrite,
    input  logic [ADDRLEN-1:0] if_addr,
    output logic [1:0]         if_status,
    output logic [INSTLEN-1:0] data_from_mem,
    input  logic               ls_req,
    input  logic               ls_we,
    input  logic [1:0]         ls_size,
    input  logic [ADDRLEN-1:0] ls_addr,
    input  logic [31:0]        ls_wdata,
    output logic [1:0]         ls_status,
    output logic [31:0]        ls_rdata,
    input  logic [7:0]         mem_din,
    output logic [7:0]         mem_dout,
    output logic [ADDRLEN-1:0] mem_a,
    output logic               mem_wr
`ifdef MC_IO_STALL_EN
    ,
    input  logic               io_buffer_full
`endif
);

    // Counter must reach 4 + RAM_LAT, the last edge of a word read
    localparam int CW = $clog2(4 + RAM_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_IF_RD, S_LS_RD, S_LS_WR, S_DONE_IF, S_DONE_LS
    } state_t;

    state_t              r_state, w_next;
    logic [CW-1:0]       r_cnt;       // edges elapsed since the accept edge
    logic [2:0]          r_len;       // bytes in the current access
    logic [ADDRLEN-1:0]  r_addr;
    logic [31:0]         r_wdata;
    logic [ADDRLEN-1:0]  r_mem_a;
    logic [7:0]          r_mem_dout;
    logic                r_mem_wr;
    logic [INSTLEN-1:0]  r_if_data;
    logic [31:0]         r_ls_rdata;

    logic                w_ls_ok;
    logic                w_wr_hold;
    logic                w_last_rd;
    logic                w_last_wr;
    logic [1:0]          w_rd_idx;
    logic [1:0]          w_wr_idx;

`ifdef MC_IO_STALL_EN
    // IO stores wait for room in the IO output FIFO, both at accept and mid-burst
    assign w_ls_ok   = ls_req && !(ls_we && (ls_addr >= IO_ADDR) && io_buffer_full);
    assign w_wr_hold = io_buffer_full && (r_addr >= IO_ADDR);
`else
    assign w_ls_ok   = ls_req;
    assign w_wr_hold = 1'b0;
`endif

    // Read byte k lands RAM_LAT+1 edges after its address was driven
    assign w_rd_idx  = 2'(r_cnt - CW'(RAM_LAT + 1));
    assign w_wr_idx  = r_cnt[1:0];
    assign w_last_rd = (r_cnt == CW'(r_len) + CW'(RAM_LAT));
    assign w_last_wr = (r_cnt == CW'(r_len));

    assign mem_a         = r_mem_a;
    assign mem_dout      = r_mem_dout;
    assign mem_wr        = r_mem_wr;
    assign data_from_mem = r_if_data;
    assign ls_rdata      = r_ls_rdata;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next state and requester status
    always_comb begin
        w_next    = r_state;
        if_status = ST_INIT;
        ls_status = ST_INIT;
        case (r_state)
            S_IDLE: begin
                if (w_ls_ok)           w_next = ls_we ? S_LS_WR : S_LS_RD;
                else if (if_readwrite) w_next = S_IF_RD;
            end
            S_IF_RD: begin
                if_status = ST_BUSY;
                if (flush)          w_next = S_IDLE;
                else if (w_last_rd) w_next = S_DONE_IF;
            end
            S_LS_RD: begin
                ls_status = ST_BUSY;
                if (w_last_rd) w_next = S_DONE_LS;
            end
            S_LS_WR: begin
                ls_status = ST_BUSY;
                if (!w_wr_hold && w_last_wr) w_next = S_DONE_LS;
            end
            S_DONE_IF: begin
                if_status = ST_DONE;
                w_next    = S_IDLE;
            end
            S_DONE_LS: begin
                ls_status = ST_DONE;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Request latching, byte-serial address/data drive and read-byte assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mem_a    <= '0;
            r_mem_dout <= '0;
            r_mem_wr   <= 1'b0;
            r_if_data  <= '0;
            r_ls_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ls_ok) begin
                        r_addr  <= ls_addr;
                        r_wdata <= ls_wdata;
                        r_len   <= size_to_len(ls_size);
                        r_mem_a <= ls_addr;
                        r_cnt   <= CW'(1);
                        if (ls_we) begin
                            r_mem_dout <= ls_wdata[7:0];
                            r_mem_wr   <= 1'b1;
                        end else begin
                            r_ls_rdata <= '0;   // zero-extension for short loads
                        end
                    end else if (if_readwrite) begin
                        r_addr  <= if_addr;
                        r_len   <= 3'd4;
                        r_mem_a <= if_addr;
                        r_cnt   <= CW'(1);
                    end
                end
                S_IF_RD, S_LS_RD: begin
                    if (!(r_state == S_IF_RD && flush)) begin
                        if (r_cnt < CW'(r_len))
                            r_mem_a <= r_addr + 32'(r_cnt);
                        if (r_cnt >= CW'(RAM_LAT + 1)) begin
                            if (r_state == S_IF_RD) r_if_data[{w_rd_idx, 3'b000} +: 8] <= mem_din;
                            else                    r_ls_rdata[{w_rd_idx, 3'b000} +: 8] <= mem_din;
                        end
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_LS_WR: begin
                    if (w_wr_hold) begin
                        r_mem_wr <= 1'b0;
                    end else if (r_cnt < CW'(r_len)) begin
                        r_mem_a    <= r_addr + 32'(r_cnt);
                        r_mem_dout <= r_wdata[{w_wr_idx, 3'b000} +: 8];
                        r_mem_wr   <= 1'b1;
                        r_cnt      <= r_cnt + CW'(1);
                    end else begin
                        r_mem_wr <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model of one-cycle read latency.
// Drives and samples on the falling edge; every wait is bounded.
// Covers MC_IO_STALL_EN stimulus when that macro is defined.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        if_readwrite = 1'b0;
    logic [31:0] if_addr = '0;
    logic [1:0]  if_status;
    logic [31:0] data_from_mem;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [1:0]  ls_size = SIZE_B;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [1:0]  ls_status;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
`ifdef MC_IO_STALL_EN
    logic        io_buffer_full = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] ram [65536];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .if_readwrite(if_readwrite), .if_addr(if_addr), .if_status(if_status),
        .data_from_mem(data_from_mem),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_status(ls_status), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
`ifdef MC_IO_STALL_EN
        , .io_buffer_full(io_buffer_full)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: registered read (one cycle latency), write on mem_wr
    always @(posedge clk) begin
        mem_din <= ram[mem_a[15:0]];
        if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // Count falling edges until the chosen requester shows Done; -1 on timeout
    task automatic await_done(input bit is_if, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            nxt();
            if ((is_if ? if_status : ls_status) == ST_DONE) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int ndone;
        logic [7:0] wbytes [4];
        wbytes[0] = 8'hEF; wbytes[1] = 8'hBE; wbytes[2] = 8'hAD; wbytes[3] = 8'hDE;

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
        ram[16'h2004] = 8'h78; ram[16'h2005] = 8'h56; ram[16'h2006] = 8'h34; ram[16'h2007] = 8'h12;
        ram[16'h0010] = 8'h80;

        // Reset state
        nxt(); nxt();
        chk("rst_if_status", 32'(if_status), 32'(ST_INIT));
        chk("rst_ls_status", 32'(ls_status), 32'(ST_INIT));
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_data", data_from_mem, 32'h0);
        chk("rst_rdata", ls_rdata, 32'h0);
        rst = 1'b1;
        nxt();

        // IF fetch 0x1000: Busy after E0..E4, Done only after E5
        if_readwrite = 1'b1; if_addr = 32'h1000;
        for (int k = 0; k <= 6; k++) begin
            nxt();
            if (k == 0) begin
                if_readwrite = 1'b0; if_addr = 32'hBAD0_0000;
                chk("if_mem_a_e0", mem_a, 32'h1000);
            end
            chk($sformatf("if_status_e%0d", k), 32'(if_status),
                32'(k < 5 ? ST_BUSY : (k == 5 ? ST_DONE : ST_INIT)));
            if (k == 3) chk("if_mem_a_e3", mem_a, 32'h1003);
            if (k == 5) chk("if_data", data_from_mem, 32'h0000_0513);
            if (k == 6) chk("if_mem_a_hold", mem_a, 32'h1003);
        end

        // Store word 0xDEADBEEF @0x2000
        ls_req = 1'b1; ls_we = 1'b1; ls_size = SIZE_W; ls_addr = 32'h2000; ls_wdata = 32'hDEAD_BEEF;
        for (int k = 0; k <= 5; k++) begin
            nxt();
            if (k == 0) begin
                ls_req = 1'b0; ls_addr = '0; ls_wdata = '0;
            end
            if (k < 4) begin
                chk($sformatf("st_wr_e%0d", k), 32'(mem_wr), 32'h1);
                chk($sformatf("st_a_e%0d", k), mem_a, 32'h2000 + 32'(k));
                chk($sformatf("st_dout_e%0d", k), 32'(mem_dout), 32'(wbytes[k]));
                chk($sformatf("st_status_e%0d", k), 32'(ls_status), 32'(ST_BUSY));
            end else if (k == 4) begin
                chk("st_wr_e4", 32'(mem_wr), 32'h0);
                chk("st_status_e4", 32'(ls_status), 32'(ST_DONE));
            end else begin
                chk("st_status_e5", 32'(ls_status), 32'(ST_INIT));
            end
        end
        chk("st_ram", {ram[16'h2003], ram[16'h2002], ram[16'h2001], ram[16'h2000]}, 32'hDEAD_BEEF);

        // Simultaneous requests: LS load byte first, IF accepted after DONE_LS
        if_readwrite = 1'b1; if_addr = 32'h1000;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = SIZE_B; ls_addr = 32'h10;
        nxt();
        ls_req = 1'b0;
        chk("pri_ls_e0", 32'(ls_status), 32'(ST_BUSY));
        chk("pri_if_e0", 32'(if_status), 32'(ST_INIT));
        nxt();
        chk("pri_if_e1", 32'(if_status), 32'(ST_INIT));
        nxt();
        chk("pri_ls_e2", 32'(ls_status), 32'(ST_DONE));
        chk("pri_rdata", ls_rdata, 32'h80);
        chk("pri_if_e2", 32'(if_status), 32'(ST_INIT));
        nxt();
        chk("pri_ls_e3", 32'(ls_status), 32'(ST_INIT));
        chk("pri_if_e3", 32'(if_status), 32'(ST_INIT));
        nxt();
        chk("pri_if_e4", 32'(if_status), 32'(ST_BUSY));
        if_readwrite = 1'b0;
        await_done(1'b1, cyc);
        chk("pri_if_lat", 32'(cyc), 32'd5);
        chk("pri_if_data", data_from_mem, 32'h0000_0513);
        nxt();

        // Flush two cycles into a fetch, then fetch 0x2004
        if_readwrite = 1'b1; if_addr = 32'h1000;
        nxt();
        chk("fl_busy_e0", 32'(if_status), 32'(ST_BUSY));
        if_readwrite = 1'b0;
        nxt();
        flush = 1'b1;
        nxt();
        flush = 1'b0;
        chk("fl_init_e2", 32'(if_status), 32'(ST_INIT));
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            nxt();
            if (if_status != ST_INIT) ndone++;
        end
        chk("fl_no_done", 32'(ndone), 32'd0);
        if_readwrite = 1'b1; if_addr = 32'h2004;
        nxt();
        if_readwrite = 1'b0;
        await_done(1'b1, cyc);
        chk("fl2_lat", 32'(cyc), 32'd5);
        chk("fl2_data", data_from_mem, 32'h1234_5678);
        nxt();

        // Asynchronous reset in the middle of a store
        ls_req = 1'b1; ls_we = 1'b1; ls_size = SIZE_W; ls_addr = 32'h3000; ls_wdata = 32'h1122_3344;
        nxt();
        ls_req = 1'b0;
        nxt();
        chk("ar_wr_before", 32'(mem_wr), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("ar_mem_wr", 32'(mem_wr), 32'h0);
        chk("ar_mem_a", mem_a, 32'h0);
        chk("ar_mem_dout", 32'(mem_dout), 32'h0);
        chk("ar_ls_status", 32'(ls_status), 32'(ST_INIT));
        chk("ar_data", data_from_mem, 32'h0);
        nxt();
        rst = 1'b1;
        nxt();

        // Load half across the 2^32 wrap
        ram[16'hFFFF] = 8'hCD; ram[16'h0000] = 8'hAB;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = SIZE_H; ls_addr = 32'hFFFF_FFFF;
        nxt();
        ls_req = 1'b0;
        chk("wrap_a_e0", mem_a, 32'hFFFF_FFFF);
        nxt();
        chk("wrap_a_e1", mem_a, 32'h0);
        await_done(1'b0, cyc);
        chk("wrap_lat", 32'(cyc), 32'd2);
        chk("wrap_rdata", ls_rdata, 32'h0000_ABCD);
        nxt();

`ifdef MC_IO_STALL_EN
        // IO store held off while the IO FIFO is full
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = SIZE_B; ls_addr = 32'h0003_0000; ls_wdata = 32'h5A;
        for (int k = 0; k < 3; k++) begin
            nxt();
            chk($sformatf("io_wait_st%0d", k), 32'(ls_status), 32'(ST_INIT));
            chk($sformatf("io_wait_wr%0d", k), 32'(mem_wr), 32'h0);
        end
        io_buffer_full = 1'b0;
        nxt();
        ls_req = 1'b0;
        chk("io_wr", 32'(mem_wr), 32'h1);
        chk("io_dout", 32'(mem_dout), 32'h5A);
        nxt();
        chk("io_wr_end", 32'(mem_wr), 32'h0);
        chk("io_done", 32'(ls_status), 32'(ST_DONE));
        nxt();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
